// File: rtl/i2s_tx_frame_if.sv
// Frame input port of the I2S/TDM transmitter.
// Handshake: a frame transfers on a falling edge of the serial clock where
// in_valid_i and in_ready_o are both high. While in_valid_i is high and
// in_ready_o is low, the upstream holds in_data_i stable. in_ready_o never
// depends combinationally on in_valid_i.
interface i2s_tx_frame_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16
);
  logic [NUM_CH*SAMPLE_W-1:0] in_data_i;   // channel 0 in the MSBs
  logic                       in_valid_i;
  logic                       in_ready_o;

  modport master (output in_data_i, output in_valid_i, input in_ready_o);
  modport slave  (input in_data_i, input in_valid_i, output in_ready_o);
endinterface

// File: rtl/i2s_tx_frame.sv
// Parametrised I2S / left-justified / TDM serial transmitter.
// Frames of NUM_CH samples are queued in a 2-entry buffer, laid out into
// SLOT_W-bit slots (samples MSB-aligned, zero padded below) and shifted out
// MSB first. A frame boundary with an empty buffer sends a muted frame and
// raises underrun_o for that whole frame. Everything moves on the falling
// edge of sclk_i.
module i2s_tx_frame #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int FORMAT   = 0
) (
  input  logic           sclk_i,
  input  logic           rst_i,
  i2s_tx_frame_if.slave  in_if,
  output logic           ws_o,
  output logic           sdata_o,
  output logic           underrun_o,
  output logic           dbg_state_o
);
  localparam int FRAME  = NUM_CH * SLOT_W;
  localparam int DATA_W = NUM_CH * SAMPLE_W;
  localparam int CNT_W  = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(FRAME / 2);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(FRAME / 2 - 1);

  // RESET only exists for the first edge after release, which opens frame 0.
  typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic [FRAME-1:0]  sh_q, sh_d;
  logic [FRAME-1:0]  head_pad;
  logic              ws_q, ws_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              push, pop, frame_start;

  // Lay the buffer head out into slots: sample MSB-aligned, zeros below.
  always_comb begin
    head_pad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      head_pad[FRAME-1-c*SLOT_W -: SAMPLE_W] =
        fifo_q[rd_ptr_q][(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Bit counter, frame buffer, serialiser and output next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sh_d        = sh_q << 1;
    underrun_d  = underrun_q;
    frame_start = 1'b0;
    push        = in_if.in_valid_i & ready_q;

    case (state_q)
      ST_RESET: begin
        state_d     = ST_RUN;
        cnt_d       = '0;
        frame_start = 1'b1;
      end
      ST_RUN: begin
        frame_start = (cnt_q == LAST);
        cnt_d       = frame_start ? '0 : cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Pop only what was already held before this edge: no same-edge bypass.
    pop = frame_start & (count_q != 2'd0);

    if (frame_start) begin
      sh_d       = pop ? head_pad : '0;
      underrun_d = ~pop;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = in_if.in_data_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != 2'd2);

    // Philips mode runs ws one bit ahead and data one bit behind the frame
    // counter; the delayed data bit is whatever left the top of the shift
    // register on the previous period.
    if (FORMAT == 1) begin
      ws_d    = (cnt_d >= HALF);
      sdata_d = sh_d[FRAME-1];
    end else begin
      ws_d    = (cnt_d >= HALF_M1) && (cnt_d != LAST);
      sdata_d = sh_q[FRAME-1];
    end
  end

  // State register; reset flushes the buffer and forces all outputs low.
  always_ff @(negedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ready_q    <= 1'b0;
      sh_q       <= '0;
      ws_q       <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      sh_q       <= sh_d;
      ws_q       <= ws_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign ws_o             = ws_q;
  assign sdata_o          = sdata_q;
  assign underrun_o       = underrun_q;
  assign in_if.in_ready_o = ready_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_i2s_tx_frame.sv
// Bench for i2s_tx_frame: three configurations side by side (Philips stereo
// 16/16, left-justified 24-in-32 stereo, 8-channel TDM), each checked every
// bit period against a frame-level model, plus a table of hand-derived bit
// periods and hand-written backpressure / underrun / reset sequences.
module tb_i2s_tx_frame;
  localparam int SW_C  [3] = '{16, 24, 16};
  localparam int SLW_C [3] = '{16, 32, 16};
  localparam int NCH_C [3] = '{2, 2, 8};
  localparam int FMT_C [3] = '{0, 1, 0};

  logic         sclk;
  logic         rst_n;
  logic [255:0] data_v [3];
  logic [2:0]   valid_v;
  logic [2:0]   ready_v, ws_v, sd_v, ur_v, dbg_v;

  int n_checks = 0;
  int n_fail   = 0;
  int abs_p    = -1;   // bit periods since reset release (0 = frame 0, bit 0)

  // model state per configuration
  logic [255:0] exp_q [3][$];
  logic [255:0] cur_m [3];
  int           k_m   [3];
  logic         run_m [3];
  logic         last_m[3];
  logic         ur_m  [3];
  logic         mr    [3];
  logic         ews   [3];
  logic         esd   [3];

  typedef struct {
    int   p;
    logic ws;
    logic sd;
    logic ur;
  } vec_t;
  vec_t tbl [15];

  // ---------------- clock ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ---------------- DUTs ----------------
  i2s_tx_frame_if #(.NUM_CH(2), .SAMPLE_W(16)) if_a ();
  i2s_tx_frame_if #(.NUM_CH(2), .SAMPLE_W(24)) if_b ();
  i2s_tx_frame_if #(.NUM_CH(8), .SAMPLE_W(16)) if_c ();

  assign if_a.in_data_i  = data_v[0][31:0];
  assign if_b.in_data_i  = data_v[1][47:0];
  assign if_c.in_data_i  = data_v[2][127:0];
  assign if_a.in_valid_i = valid_v[0];
  assign if_b.in_valid_i = valid_v[1];
  assign if_c.in_valid_i = valid_v[2];
  assign ready_v[0]      = if_a.in_ready_o;
  assign ready_v[1]      = if_b.in_ready_o;
  assign ready_v[2]      = if_c.in_ready_o;

  i2s_tx_frame #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(2), .FORMAT(0)) dut_a (
    .sclk_i(sclk), .rst_i(rst_n), .in_if(if_a),
    .ws_o(ws_v[0]), .sdata_o(sd_v[0]), .underrun_o(ur_v[0]), .dbg_state_o(dbg_v[0]));
  i2s_tx_frame #(.SAMPLE_W(24), .SLOT_W(32), .NUM_CH(2), .FORMAT(1)) dut_b (
    .sclk_i(sclk), .rst_i(rst_n), .in_if(if_b),
    .ws_o(ws_v[1]), .sdata_o(sd_v[1]), .underrun_o(ur_v[1]), .dbg_state_o(dbg_v[1]));
  i2s_tx_frame #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(8), .FORMAT(0)) dut_c (
    .sclk_i(sclk), .rst_i(rst_n), .in_if(if_c),
    .ws_o(ws_v[2]), .sdata_o(sd_v[2]), .underrun_o(ur_v[2]), .dbg_state_o(dbg_v[2]));

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DATA(k) of a frame: sample of slot k/SLOT_W, MSB first, zeros past SAMPLE_W.
  function automatic logic data_bit(input int d, input logic [255:0] fr, input int k);
    int s, b;
    s = k / SLW_C[d];
    b = k % SLW_C[d];
    if (b >= SW_C[d]) return 1'b0;
    return fr[(NCH_C[d] - 1 - s) * SW_C[d] + (SW_C[d] - 1 - b)];
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Call right after a posedge; returns at the posedge after acceptance.
  task automatic push(input int d, input logic [255:0] fr, output int acc);
    int g;
    g = 0;
    acc = -1;
    data_v[d]  = fr;
    valid_v[d] = 1'b1;
    while (!ready_v[d] && g < 400) begin
      @(posedge sclk);
      g++;
    end
    chk($sformatf("push_accept_dut%0d", d), {31'd0, g < 400}, 32'd1);
    acc = abs_p + 1;
    @(posedge sclk);
    valid_v[d] = 1'b0;
  endtask

  // Leaves the caller at negedge+2 of bit period p.
  task automatic wait_abs(input int p);
    int g;
    g = 0;
    while (abs_p != p && g < 3000) begin
      @(negedge sclk);
      #2;
      g++;
    end
    if (g >= 3000) chk($sformatf("wait_period_%0d", p), 32'd0, 32'd1);
  endtask

  task automatic rand_run(input int d, input int n);
    int acc;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge sclk);
      push(d, rand_frame(), acc);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  always @(negedge sclk) begin : model
    int   fr, k;
    logic pushed;
    if (!rst_n) begin
      abs_p = -1;
      for (int d = 0; d < 3; d++) begin
        run_m[d] = 1'b0; exp_q[d].delete(); cur_m[d] = '0; last_m[d] = 1'b0;
        mr[d] = 1'b0; ur_m[d] = 1'b0; ews[d] = 1'b0; esd[d] = 1'b0;
      end
    end else begin
      abs_p = run_m[0] ? abs_p + 1 : 0;
      for (int d = 0; d < 3; d++) begin
        fr     = NCH_C[d] * SLW_C[d];
        pushed = valid_v[d] && mr[d];
        if (!run_m[d]) begin
          run_m[d] = 1'b1;
          k_m[d]   = 0;
        end else begin
          k_m[d] = (k_m[d] + 1) % fr;
        end
        if (k_m[d] == 0) begin
          last_m[d] = data_bit(d, cur_m[d], fr - 1);
          if (exp_q[d].size() > 0) begin
            cur_m[d] = exp_q[d].pop_front();
            ur_m[d]  = 1'b0;
          end else begin
            cur_m[d] = '0;
            ur_m[d]  = 1'b1;
          end
        end
        if (pushed) exp_q[d].push_back(data_v[d]);
        mr[d] = (exp_q[d].size() < 2);
        k = k_m[d];
        if (FMT_C[d] == 1) begin
          ews[d] = (k >= fr / 2);
          esd[d] = data_bit(d, cur_m[d], k);
        end else begin
          ews[d] = (((k + 1) % fr) >= fr / 2);
          esd[d] = (k == 0) ? last_m[d] : data_bit(d, cur_m[d], k - 1);
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_ws", d),       {31'd0, ws_v[d]},    {31'd0, ews[d]});
      chk($sformatf("dut%0d_sdata", d),    {31'd0, sd_v[d]},    {31'd0, esd[d]});
      chk($sformatf("dut%0d_underrun", d), {31'd0, ur_v[d]},    {31'd0, ur_m[d]});
      chk($sformatf("dut%0d_ready", d),    {31'd0, ready_v[d]}, {31'd0, mr[d]});
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc, acc3, ur_cnt;

    // Basic I2S on dut_a: frame 0 muted, {A5C3, 3C5A} in frame 1.
    // Bits: A5C3 = 1010_0101_1100_0011, 3C5A = 0011_1100_0101_1010.
    tbl[0]  = '{5,  1'b0, 1'b0, 1'b1};
    tbl[1]  = '{31, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{32, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{33, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{34, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{35, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{37, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{46, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{47, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{48, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{49, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{51, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{62, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{63, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{64, 1'b0, 1'b0, 1'b1};

    rst_n   = 1'b0;
    valid_v = 3'b000;
    for (int d = 0; d < 3; d++) data_v[d] = '0;

    // Reset state.
    repeat (3) @(negedge sclk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ws_dut%0d", d),    {31'd0, ws_v[d]},    32'd0);
      chk($sformatf("rst_sdata_dut%0d", d), {31'd0, sd_v[d]},    32'd0);
      chk($sformatf("rst_ur_dut%0d", d),    {31'd0, ur_v[d]},    32'd0);
      chk($sformatf("rst_ready_dut%0d", d), {31'd0, ready_v[d]}, 32'd0);
      chk($sformatf("rst_state_dut%0d", d), {31'd0, dbg_v[d]},   32'd0);
    end
    @(posedge sclk);
    rst_n = 1'b1;

    fork
      begin
        push(0, 256'hA5C3_3C5A, acc);
        for (int i = 0; i < 15; i++) begin
          wait_abs(tbl[i].p);
          chk($sformatf("tbl%0d_ws", i),    {31'd0, ws_v[0]}, {31'd0, tbl[i].ws});
          chk($sformatf("tbl%0d_sdata", i), {31'd0, sd_v[0]}, {31'd0, tbl[i].sd});
          chk($sformatf("tbl%0d_ur", i),    {31'd0, ur_v[0]}, {31'd0, tbl[i].ur});
        end
      end
      push(1, 256'h800001_7FFFFE, acc);
      push(2, 256'h1111_2222_3333_4444_5555_6666_7777_8888, acc);
    join

    // Reset in the middle of a data frame with one frame still queued.
    @(posedge sclk);
    push(0, 256'hFFFF_FFFF, acc);
    push(0, 256'h0F0F_F0F0, acc);
    wait_abs(3 * 32 + 10);
    chk("pre_rst_sdata", {31'd0, sd_v[0]},    32'd1);
    chk("pre_rst_ready", {31'd0, ready_v[0]}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ws",    {31'd0, ws_v[0]},    32'd0);
    chk("async_rst_sdata", {31'd0, sd_v[0]},    32'd0);
    chk("async_rst_ur",    {31'd0, ur_v[0]},    32'd0);
    chk("async_rst_ready", {31'd0, ready_v[0]}, 32'd0);
    repeat (3) @(posedge sclk);
    rst_n = 1'b1;

    // Backpressure: three pushes in frame 0 after release.
    push(0, rand_frame(), acc);
    chk("bp_acc1", acc, 32'd1);
    push(0, rand_frame(), acc);
    chk("bp_acc2", acc, 32'd2);
    chk("bp_ready_full", {31'd0, ready_v[0]}, 32'd0);
    chk("post_rst_muted", {31'd0, ur_v[0]}, 32'd1);
    push(0, rand_frame(), acc3);
    chk("bp_acc3", acc3, 32'd33);
    wait_abs(40);
    chk("bp_f1_ur", {31'd0, ur_v[0]}, 32'd0);
    wait_abs(72);
    chk("bp_f2_ur", {31'd0, ur_v[0]}, 32'd0);
    wait_abs(104);
    chk("bp_f3_ur", {31'd0, ur_v[0]}, 32'd0);

    // Underrun recovery: frame 4 muted, push during it restores frame 5.
    ur_cnt = 0;
    fork
      begin
        for (int p = 127; p <= 160; p++) begin
          wait_abs(p);
          if (ur_v[0]) ur_cnt++;
        end
        chk("ur_frame_end", {31'd0, ur_v[0]}, 32'd0);
      end
      begin
        wait_abs(135);
        @(posedge sclk);
        push(0, rand_frame(), acc);
      end
    join
    chk("ur_period_count", ur_cnt, 32'd32);

    // Randomised traffic on all three configurations.
    @(posedge sclk);
    fork
      rand_run(0, 30);
      rand_run(1, 12);
      rand_run(2, 8);
    join
    repeat (400) @(posedge sclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
